// File: rtl/mioc_flop_pkg.sv
// mioc_flop_pkg: shared op/state encodings and parameter floors for the MIOC flop driver
package mioc_flop_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_PRESET = 2'd1, OP_CLEAR = 2'd2, OP_READ = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE, RESP} state_e;
  localparam int SETUP_MIN = 1;
  localparam int PULSE_MIN = 1;
  localparam int HOLD_MIN = 1;
  localparam int SETTLE_MIN = 0;
  localparam int SYNC_STAGES = 2;
  function automatic int clamp_lo(int v, int lo);
    return v < lo ? lo : v;
  endfunction
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mioc_flop_drv_if.sv
// mioc_flop_drv_if: command/response handshake bundle between host and flop driver
interface mioc_flop_drv_if;
  import mioc_flop_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  op_e cmd_op;
  logic cmd_d;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_q;
  logic rsp_err;
  modport master (output cmd_valid, cmd_op, cmd_d, rsp_ready, input cmd_ready, rsp_valid, rsp_q, rsp_err);
  modport slave (input cmd_valid, cmd_op, cmd_d, rsp_ready, output cmd_ready, rsp_valid, rsp_q, rsp_err);
endinterface

// File: rtl/mioc_flop_sync.sv
// mioc_flop_sync: 2-flop synchronizer for the flop's asynchronous outputs
module mioc_flop_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic y
);
  logic m;
  always_ff @(posedge clk)
    if (!rst_n) {y, m} <= 2'b00;
    else {y, m} <= {m, a};
endmodule

// File: rtl/mioc_flop_drv.sv
// mioc_flop_drv: sequences preset/clear/data/clock pins of the MIOC flop and samples q/qbar back.
// Define MIOC_FLOP_DRV_CHECK_EN to also flag responses that differ from the tracked expected state.
module mioc_flop_drv
  import mioc_flop_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC = 1,
  parameter int SETTLE_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  mioc_flop_drv_if.slave bus,
  output logic in1,
  output logic in2,
  output logic in3,
  output logic in4,
  input  logic q,
  input  logic qbar
);
  localparam int S = clamp_lo(SETUP_CYC, SETUP_MIN);
  localparam int P = clamp_lo(PULSE_CYC, PULSE_MIN);
  localparam int H = clamp_lo(HOLD_CYC, HOLD_MIN);
  localparam int E = clamp_lo(SETTLE_CYC, SETTLE_MIN);
  localparam int W = $clog2(max2(max2(S, P), max2(H, E))) + 3;
  localparam logic [W-1:0] S_LD = W'(S - 1);
  localparam logic [W-1:0] P_LD = W'(P - 1);
  localparam logic [W-1:0] H_LD = W'(H - 1);
  localparam logic [W-1:0] E_LD = W'(E + SYNC_STAGES - 1);
  state_e st;
  op_e op;
  logic [W-1:0] cnt;
  logic qs, qbs, err;
  logic done;
  assign done = cnt == '0;
  mioc_flop_sync u_sync_q (.clk(clk), .rst_n(rst_n), .a(q), .y(qs));
  mioc_flop_sync u_sync_qb (.clk(clk), .rst_n(rst_n), .a(qbar), .y(qbs));
`ifdef MIOC_FLOP_DRV_CHECK_EN
  logic exp_q;
  always_ff @(posedge clk)
    if (!rst_n) exp_q <= 1'b0;
    else if (st == IDLE && bus.cmd_valid && bus.cmd_ready && bus.cmd_op != OP_READ)
      exp_q <= bus.cmd_op == OP_WRITE ? bus.cmd_d : bus.cmd_op == OP_PRESET;
  assign err = (qs == qbs) || (qs != exp_q);
`else
  assign err = qs == qbs;
`endif
  // Pins are updated on the transition into each phase so every output stays a clean register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      op <= OP_WRITE;
      cnt <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_q <= 1'b0;
      bus.rsp_err <= 1'b0;
      in1 <= 1'b1;
      in2 <= 1'b0;
      in3 <= 1'b0;
      in4 <= 1'b1;
    end else begin
      case (st)
        IDLE:
          if (bus.cmd_valid && bus.cmd_ready) begin
            op <= bus.cmd_op;
            bus.cmd_ready <= 1'b0;
            case (bus.cmd_op)
              OP_WRITE: begin st <= SETUP; cnt <= S_LD; in3 <= bus.cmd_d; end
              OP_PRESET: begin st <= PULSE; cnt <= P_LD; in1 <= 1'b0; end
              OP_CLEAR: begin st <= PULSE; cnt <= P_LD; in4 <= 1'b0; end
              default: begin st <= SETTLE; cnt <= E_LD; end
            endcase
          end else bus.cmd_ready <= 1'b1;
        SETUP:
          if (done) begin st <= PULSE; cnt <= P_LD; in2 <= 1'b1; end
          else cnt <= cnt - 1'b1;
        PULSE:
          if (done) begin
            in1 <= 1'b1;
            in2 <= 1'b0;
            in4 <= 1'b1;
            st <= op == OP_WRITE ? HOLD : SETTLE;
            cnt <= op == OP_WRITE ? H_LD : E_LD;
          end else cnt <= cnt - 1'b1;
        HOLD:
          if (done) begin st <= SETTLE; cnt <= E_LD; in3 <= 1'b0; end
          else cnt <= cnt - 1'b1;
        SETTLE:
          if (done) begin
            st <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_q <= qs;
            bus.rsp_err <= err;
          end else cnt <= cnt - 1'b1;
        RESP:
          if (bus.rsp_ready) begin
            st <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mioc_flop_drv.sv
// tb_mioc_flop_drv: directed scoreboard bench driving the flop driver against a behavioural flop model
module tb_mioc_flop_drv;
  import mioc_flop_pkg::*;
  typedef struct packed {logic q; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in1, in2, in3, in4;
  logic fq;
  logic ovr = 1'b0, ovr_q = 1'b0, ovr_qb = 1'b0;
  logic q, qbar;
  int n_cmp = 0, n_err = 0;
  exp_t sb[$];
  mioc_flop_drv_if bus ();
  mioc_flop_drv dut (.clk(clk), .rst_n(rst_n), .bus(bus), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .q(q), .qbar(qbar));
  always #5 clk = ~clk;
  always @(posedge in2 or negedge in1 or negedge in4)
    if (!in1) fq <= 1'b1;
    else if (!in4) fq <= 1'b0;
    else fq <= in3;
  assign q = ovr ? ovr_q : fq;
  assign qbar = ovr ? ovr_qb : ~fq;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one command, records pin activity per cycle after acceptance, checks latency and scoreboard.
  task automatic run_cmd(input string tag, input op_e op, input logic d, input int lat, input logic xq,
                         input logic xerr, input int stall, output int lo1, output int lo4, output int hi2,
                         output int f2, output int f3);
    int n = 0, w = 0;
    logic viol = 1'b0, unstable = 1'b0, rq, re;
    exp_t e;
    lo1 = 0; lo4 = 0; hi2 = 0; f2 = -1; f3 = -1;
    while (!bus.cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_d = d;
    sb.push_back('{q: xq, err: xerr});
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (!in1 && !in4) viol = 1'b1;
      if (!in1) lo1++;
      if (!in4) lo4++;
      if (in2) hi2++;
      if (in2 && f2 < 0) f2 = n;
      if (in3 && f3 < 0) f3 = n;
      if (bus.rsp_valid) break;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_pin_excl"}, viol, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_q"}, bus.rsp_q, e.q);
      chk({tag, "_rsp_err"}, bus.rsp_err, e.err);
    end else chk({tag, "_sb_empty"}, 1, 0);
    rq = bus.rsp_q; re = bus.rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_q !== rq || bus.rsp_err !== re || bus.cmd_ready) unstable = 1'b1;
    end
    if (stall > 0) chk({tag, "_stall_stable"}, unstable, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rsp_drop"}, bus.rsp_valid, 0);
  endtask

  initial begin
    int lo1, lo4, hi2, f2, f3;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_READ; bus.cmd_d = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_q", bus.rsp_q, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_pins", {in1, in2, in3, in4}, 4'b1001);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", bus.cmd_ready, 1);

    run_cmd("clear", OP_CLEAR, 1'b0, 8, 1'b0, 1'b0, 0, lo1, lo4, hi2, f2, f3);
    chk("clear_in4_low", lo4, 2);
    chk("clear_in2_quiet", hi2, 0);

    run_cmd("write1", OP_WRITE, 1'b1, 11, 1'b1, 1'b0, 0, lo1, lo4, hi2, f2, f3);
    chk("write1_setup", f2 - f3, 2);
    chk("write1_in2_high", hi2, 2);

    run_cmd("preset", OP_PRESET, 1'b0, 8, 1'b1, 1'b0, 0, lo1, lo4, hi2, f2, f3);
    chk("preset_in1_low", lo1, 2);
    run_cmd("read_stall", OP_READ, 1'b0, 6, 1'b1, 1'b0, 5, lo1, lo4, hi2, f2, f3);
    chk("read_no_pins", lo1 + lo4 + hi2, 0);

    ovr = 1'b1; ovr_q = 1'b1; ovr_qb = 1'b1;
    run_cmd("read_qeq", OP_READ, 1'b0, 6, 1'b1, 1'b1, 0, lo1, lo4, hi2, f2, f3);
    ovr = 1'b0;

    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_d = 1'b0;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_in2_before", in2, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_pins", {in1, in2, in4}, 3'b101);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);

    ovr = 1'b1; ovr_q = 1'b0; ovr_qb = 1'b1;
`ifdef MIOC_FLOP_DRV_CHECK_EN
    run_cmd("write_stuck", OP_WRITE, 1'b1, 11, 1'b0, 1'b1, 0, lo1, lo4, hi2, f2, f3);
`else
    run_cmd("write_stuck", OP_WRITE, 1'b1, 11, 1'b0, 1'b0, 0, lo1, lo4, hi2, f2, f3);
`endif
    ovr = 1'b0;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
